// File: rtl/dvp_cap_pkg.sv
// Shared definitions for the DVP pixel capture path: FSM state codes,
// default bus widths and the beat-counter width helper.
package dvp_cap_pkg;

   localparam int DVP_DATA_W = 8;
   localparam int DVP_BPP    = 2;
   localparam int DVP_XY_W   = 12;

   localparam logic [1:0] ST_WAIT  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_FRAME = 2'd2;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int beat_cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dvp_pix_pack.sv
// Beat packer: shifts BPP input beats into one pixel word in the order chosen
// by swap_i, counts beats and reports a partially filled word.
module dvp_pix_pack
   import dvp_cap_pkg::*;
#(
   parameter int DATA_W = DVP_DATA_W,
   parameter int BPP    = DVP_BPP
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    beat_i,
   input  logic [DATA_W-1:0]       data_i,
   input  logic                    swap_i,
   output logic                    done_o,
   output logic [DATA_W*BPP-1:0]   word_o,
   output logic                    pend_o
);

   localparam int PIX_W = DATA_W * BPP;
   localparam int BW    = beat_cnt_w(BPP);
   localparam logic [BW-1:0] LAST = BW'(BPP - 1);

   logic [BW-1:0]    cnt_q, cnt_d;
   logic [PIX_W-1:0] acc_q, acc_d;

   // Swapped order shifts right so the first beat lands in the LSBs.
   generate
      if (BPP == 1) begin : g_single
         assign acc_d = data_i;
      end else begin : g_multi
         assign acc_d = swap_i ? {data_i, acc_q[PIX_W-1:DATA_W]}
                               : {acc_q[PIX_W-DATA_W-1:0], data_i};
      end
   endgenerate

   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (beat_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (beat_i) acc_q <= acc_d;
      end
   end

   assign done_o = beat_i && (cnt_q == LAST);
   assign word_o = acc_d;
   assign pend_o = (cnt_q != '0);

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP capture top: frame-skip FSM, x/y tracking and pixel/eol strobes around dvp_pix_pack.
// Define CROP_WINDOW_EN to restrict output to a window with rebased coordinates.
module dvp_pixel_capture
   import dvp_cap_pkg::*;
#(
   parameter int DATA_W   = DVP_DATA_W,
   parameter int BPP      = DVP_BPP,
   parameter int PIC_WAIT = 10,
   parameter int X_W      = DVP_XY_W,
   parameter int Y_W      = DVP_XY_W
`ifdef CROP_WINDOW_EN
   ,
   parameter int CROP_X0  = 0,
   parameter int CROP_Y0  = 0,
   parameter int CROP_W   = 1 << X_W,
   parameter int CROP_H   = 1 << Y_W
`endif
) (
   input  logic                   ov5640_pclk,
   input  logic                   sys_rst_n,
   input  logic                   ov5640_vsync,
   input  logic                   ov5640_href,
   input  logic [DATA_W-1:0]      ov5640_data,
   input  logic                   byte_swap,
   output logic                   pix_valid,
   output logic [DATA_W*BPP-1:0]  pix_data,
   output logic [X_W-1:0]         pix_x,
   output logic [Y_W-1:0]         pix_y,
   output logic                   pix_sof,
   output logic                   pix_eol,
   output logic                   err_partial,
   output logic                   capture_on
);

   localparam int PIX_W  = DATA_W * BPP;
   localparam int WAIT_W = beat_cnt_w(PIC_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((PIC_WAIT > 0) ? PIC_WAIT - 1 : 0);

   logic              vsync_d1_q, href_d1_q;
   logic [DATA_W-1:0] data_d1_q;
   logic [1:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              cap_on_q, cap_on_d, swap_q, swap_d;
   logic              sof_pend_q, sof_pend_d, line_act_q, line_act_d, fall_q, fall_d;
   logic [X_W-1:0]    x_q, x_d, x_rel, pix_x_q, pix_x_d;
   logic [Y_W-1:0]    y_q, y_d, y_rel, pix_y_q, pix_y_d;
   logic [PIX_W-1:0]  pix_data_q, pix_data_d, pack_word;
   logic              pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d;
   logic              pix_eol_q, pix_eol_d, err_q, err_d;
   logic              vs_rise, hr_rise, hr_fall, beat, pack_clr, pack_done, pack_pend;
   logic              in_win_x, in_win_y;

   assign vs_rise  = ov5640_vsync & ~vsync_d1_q;
   assign hr_rise  = ov5640_href & ~href_d1_q;
   assign hr_fall  = ~ov5640_href & href_d1_q;
   // A vsync rise aborts whatever beat is in the pipe, so it never completes a pixel.
   assign beat     = (state_q == ST_FRAME) && line_act_q && href_d1_q && !vs_rise;
   assign pack_clr = vs_rise | hr_rise | fall_q;

`ifdef CROP_WINDOW_EN
   assign in_win_x = (int'(x_q) >= CROP_X0) && (int'(x_q) < CROP_X0 + CROP_W);
   assign in_win_y = (int'(y_q) >= CROP_Y0) && (int'(y_q) < CROP_Y0 + CROP_H);
   assign x_rel    = x_q - X_W'(CROP_X0);
   assign y_rel    = y_q - Y_W'(CROP_Y0);
`else
   assign in_win_x = 1'b1;
   assign in_win_y = 1'b1;
   assign x_rel    = x_q;
   assign y_rel    = y_q;
`endif

   dvp_pix_pack #(.DATA_W(DATA_W), .BPP(BPP)) u_pack (
      .clk    (ov5640_pclk),
      .rst_n  (sys_rst_n),
      .clr_i  (pack_clr),
      .beat_i (beat),
      .data_i (data_d1_q),
      .swap_i (swap_q),
      .done_o (pack_done),
      .word_o (pack_word),
      .pend_o (pack_pend)
   );

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      cap_on_d    = cap_on_q;
      swap_d      = swap_q;
      sof_pend_d  = sof_pend_q;
      line_act_d  = line_act_q;
      fall_d      = 1'b0;
      x_d         = x_q;
      y_d         = y_q;
      pix_valid_d = 1'b0;
      pix_data_d  = pix_data_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      pix_sof_d   = 1'b0;
      pix_eol_d   = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (PIC_WAIT == 0 || (vs_rise && wait_cnt_q == WAIT_LAST)) begin
               state_d  = ST_SYNC;
               cap_on_d = 1'b1;
            end else if (vs_rise) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_SYNC, ST_FRAME: begin
            if (vs_rise) begin
               state_d    = ST_FRAME;
               swap_d     = byte_swap;
               y_d        = '0;
               x_d        = '0;
               sof_pend_d = 1'b1;
               line_act_d = 1'b0;
            end else if (state_q == ST_FRAME) begin
               // Line end is handled one cycle after the fall so a final beat can complete first.
               if (fall_q) begin
                  pix_eol_d = in_win_y;
                  err_d     = pack_pend;
                  if (y_q != '1) y_d = y_q + 1'b1;
               end
               if (hr_rise) begin
                  line_act_d = 1'b1;
                  x_d        = '0;
               end
               if (pack_done) begin
                  if (in_win_x && in_win_y) begin
                     pix_valid_d = 1'b1;
                     pix_data_d  = pack_word;
                     pix_x_d     = x_rel;
                     pix_y_d     = y_rel;
                     pix_sof_d   = sof_pend_q;
                     sof_pend_d  = 1'b0;
                  end
                  if (x_q != '1) x_d = x_q + 1'b1;
               end
               if (line_act_q && hr_fall) begin
                  line_act_d = 1'b0;
                  fall_d     = 1'b1;
               end
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vsync_d1_q  <= 1'b0;
         href_d1_q   <= 1'b0;
         data_d1_q   <= '0;
         state_q     <= ST_WAIT;
         wait_cnt_q  <= '0;
         cap_on_q    <= 1'b0;
         swap_q      <= 1'b0;
         sof_pend_q  <= 1'b0;
         line_act_q  <= 1'b0;
         fall_q      <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_sof_q   <= 1'b0;
         pix_eol_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         vsync_d1_q  <= ov5640_vsync;
         href_d1_q   <= ov5640_href;
         data_d1_q   <= ov5640_data;
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         cap_on_q    <= cap_on_d;
         swap_q      <= swap_d;
         sof_pend_q  <= sof_pend_d;
         line_act_q  <= line_act_d;
         fall_q      <= fall_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
         pix_sof_q   <= pix_sof_d;
         pix_eol_q   <= pix_eol_d;
         err_q       <= err_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_sof     = pix_sof_q;
   assign pix_eol     = pix_eol_q;
   assign err_partial = err_q;
   assign capture_on  = cap_on_q;

endmodule

// File: tb/tb_dvp_pixel_capture.sv
// Scoreboard bench for dvp_pixel_capture (BPP=2, PIC_WAIT=2); the crop window
// scenario applies when CROP_WINDOW_EN is defined for both bench and design.
module tb_dvp_pixel_capture;

   localparam int DATA_W = 8, BPP = 2, PIC_WAIT = 2, X_W = 12, Y_W = 12;
   localparam int PIX_W = DATA_W * BPP;
`ifdef CROP_WINDOW_EN
   localparam int CX0 = 2, CY0 = 1, CW = 2, CH = 1;
`else
   localparam int CX0 = 0, CY0 = 0, CW = 1 << X_W, CH = 1 << Y_W;
`endif

   typedef struct {
      bit               is_pix;
      logic [PIX_W-1:0] data;
      int               x;
      int               y;
      bit               sof;
      bit               eol;
      bit               err;
      int               cyc;
   } exp_t;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic              vsync = 1'b0, href = 1'b0, bswap = 1'b0;
   logic [DATA_W-1:0] data = '0;
   logic              pix_valid, pix_sof, pix_eol, err_partial, capture_on;
   logic [PIX_W-1:0]  pix_data;
   logic [X_W-1:0]    pix_x;
   logic [Y_W-1:0]    pix_y;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0, n_fail = 0, cyc = 0;
   int   frames_seen = 0, y_m = 0;
   bit   frame_en = 1'b0, sof_m = 1'b0, swap_m = 1'b0, mon_en = 1'b0;

   dvp_pixel_capture #(
      .DATA_W(DATA_W), .BPP(BPP), .PIC_WAIT(PIC_WAIT), .X_W(X_W), .Y_W(Y_W)
`ifdef CROP_WINDOW_EN
      , .CROP_X0(CX0), .CROP_Y0(CY0), .CROP_W(CW), .CROP_H(CH)
`endif
   ) dut (
      .ov5640_pclk (clk),
      .sys_rst_n   (rst_n),
      .ov5640_vsync(vsync),
      .ov5640_href (href),
      .ov5640_data (data),
      .byte_swap   (bswap),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_sof     (pix_sof),
      .pix_eol     (pix_eol),
      .err_partial (err_partial),
      .capture_on  (capture_on)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Outputs are sampled on the falling edge, half a period after they update.
   always @(negedge clk) begin
      if (mon_en && pix_valid) begin
         if (sb.size() == 0 || !sb[0].is_pix) begin
            check("unexpected_pixel", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("pix_data", 32'(pix_data), 32'(mon_e.data));
            check("pix_x", 32'(pix_x), mon_e.x);
            check("pix_y", 32'(pix_y), mon_e.y);
            check("pix_sof", 32'(pix_sof), 32'(mon_e.sof));
            check("pix_latency", cyc, mon_e.cyc);
         end
      end
      if (mon_en && (pix_eol || err_partial)) begin
         if (sb.size() == 0 || sb[0].is_pix) begin
            check("unexpected_eol_err", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("pix_eol", 32'(pix_eol), 32'(mon_e.eol));
            check("err_partial", 32'(err_partial), 32'(mon_e.err));
            check("eol_latency", cyc, mon_e.cyc);
         end
      end
   end

   task automatic new_frame_model(input bit sw);
      frames_seen++;
      frame_en = (frames_seen > PIC_WAIT);
      y_m      = 0;
      sof_m    = 1'b1;
      swap_m   = sw;
   endtask

   // byte_swap is flipped right after the rise: the design must keep the SOF value.
   task automatic vsync_pulse(input bit sw);
      @(negedge clk);
      bswap = sw;
      vsync = 1'b1;
      new_frame_model(sw);
      @(negedge clk);
      bswap = ~sw;
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Drives n beats (first two fixed); abort ends the line with a vsync rise instead of an eol.
   task automatic line(input int n, input logic [7:0] d0, input logic [7:0] d1, input bit abort);
      logic [7:0] b, prev;
      exp_t e;
      int px;
      px   = 0;
      prev = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         b = (i == 0) ? d0 : (i == 1) ? d1 : 8'($urandom_range(0, 255));
         href = 1'b1;
         data = b;
         if ((i % 2) == 1 && frame_en) begin
            if (px >= CX0 && px < CX0 + CW && y_m >= CY0 && y_m < CY0 + CH) begin
               e = '{1'b1, (swap_m ? {b, prev} : {prev, b}), px - CX0, y_m - CY0, sof_m, 1'b0, 1'b0, cyc + 2};
               sb.push_back(e);
               sof_m = 1'b0;
            end
            px++;
         end
         prev = b;
      end
      @(negedge clk);
      href = 1'b0;
      if (abort) begin
         vsync = 1'b1;
         new_frame_model(bswap);
         repeat (3) @(negedge clk);
         vsync = 1'b0;
      end else if (frame_en) begin
         if ((y_m >= CY0 && y_m < CY0 + CH) || (n % 2) != 0) begin
            e = '{1'b0, '0, 0, 0, 1'b0, (y_m >= CY0 && y_m < CY0 + CH), ((n % 2) != 0), cyc + 2};
            sb.push_back(e);
         end
         y_m++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_data"}, 32'(pix_data), 32'd0);
      check({tag, "_x"}, 32'(pix_x), 32'd0);
      check({tag, "_y"}, 32'(pix_y), 32'd0);
      check({tag, "_sof"}, 32'(pix_sof), 32'd0);
      check({tag, "_eol"}, 32'(pix_eol), 32'd0);
      check({tag, "_err"}, 32'(err_partial), 32'd0);
      check({tag, "_capture_on"}, 32'(capture_on), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;

      // Two discarded frames, then captured frames with both byte orders.
      vsync_pulse(1'b0);
      line(8, 8'h11, 8'h22, 1'b0);
      line(8, 8'h33, 8'h44, 1'b0);
      check("capture_on_after_1", 32'(capture_on), 32'd0);
      vsync_pulse(1'b0);
      check("capture_on_after_2", 32'(capture_on), 32'd1);
      line(8, 8'h55, 8'h66, 1'b0);
      line(8, 8'h77, 8'h88, 1'b0);
      vsync_pulse(1'b0);
      line(8, 8'hA5, 8'h3C, 1'b0);
      line(8, 8'h01, 8'h02, 1'b0);
      vsync_pulse(1'b1);
      line(8, 8'hA5, 8'h3C, 1'b0);
      line(8, 8'hFF, 8'h00, 1'b0);

      // Odd-length line, then a vsync abort mid-line.
      vsync_pulse(1'b0);
      line(7, 8'h10, 8'h20, 1'b0);
      line(8, 8'h30, 8'h40, 1'b0);
      line(5, 8'h50, 8'h60, 1'b1);
      line(8, 8'h70, 8'h80, 1'b0);
      line(8, 8'h90, 8'hA0, 1'b0);

      // 6x3 frame: full output, or exactly two pixels under the crop window.
      vsync_pulse(1'b0);
      for (int r = 0; r < 3; r++) line(12, 8'(r), 8'hC0, 1'b0);
      check("sb_drain_mid", 32'(sb.size()), 32'd0);

      // Reset mid-frame while a pixel is held on the outputs.
      vsync_pulse(1'b0);
      mon_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         href = 1'b1;
         data = 8'hE0 + 8'(i);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      href = 1'b0;
      sb.delete();
      frames_seen = 0;
      frame_en    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      vsync_pulse(1'b0);
      line(8, 8'h12, 8'h34, 1'b0);
      check("capture_on_rst_1", 32'(capture_on), 32'd0);
      vsync_pulse(1'b0);
      check("capture_on_rst_2", 32'(capture_on), 32'd1);
      line(8, 8'h56, 8'h78, 1'b0);
      vsync_pulse(1'b1);
      line(8, 8'h9A, 8'hBC, 1'b0);
      line(6, 8'hDE, 8'hF0, 1'b0);

      repeat (5) @(negedge clk);
      check("sb_drain_end", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
